// File: rtl/ul_ram_pkg.sv
// Constants and encodings shared by the uplink ping-pong RAM write and read controllers.
// Both controllers must agree on the bank layout and on the meaning of the bank-state bits.
package ul_ram_pkg;

  localparam int unsigned UL_BANK_WORDS = 262;
  localparam int unsigned UL_RAM0_BASE  = 0;
  localparam int unsigned UL_RAM1_BASE  = 512;
  localparam int unsigned UL_OFF_W      = 9;

  // Bank-state bit b: 1 = bank b holds a complete frame awaiting the reader.
  localparam logic BANK_FREE = 1'b0;
  localparam logic BANK_FULL = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_WAIT = 2'd2
  } ul_wr_state_e;

endpackage

// File: rtl/ul_wr_ram_control_if.sv
// Uplink receive-word stream, bank handshake and RAM write port of the uplink write controller.
interface ul_wr_ram_control_if #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 16
);
  logic              UlDataRevEnable;
  logic [DATA_W-1:0] rxData;
  logic              rxDataValid;
  logic              rxFrameSync;
  logic [1:0]        UlRAM_rd_state;
  logic [1:0]        UlRAM_wr_state;
  logic              wrRAMEn;
  logic [ADDR_W-1:0] wrRAMAddr;
  logic [DATA_W-1:0] wrRAMData;
  logic              frameErr;
  logic              overflow;
  logic [CNT_W-1:0]  dropCount;

  modport master (
    output UlDataRevEnable, rxData, rxDataValid, rxFrameSync, UlRAM_rd_state,
    input  UlRAM_wr_state, wrRAMEn, wrRAMAddr, wrRAMData, frameErr, overflow, dropCount
  );

  modport slave (
    input  UlDataRevEnable, rxData, rxDataValid, rxFrameSync, UlRAM_rd_state,
    output UlRAM_wr_state, wrRAMEn, wrRAMAddr, wrRAMData, frameErr, overflow, dropCount
  );
endinterface

// File: rtl/ul_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module ul_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ul_wr_ram_control.sv
// Uplink ping-pong RAM write controller: writes received frames alternately into two banks
// and hands each full bank to the reader through the wr_state/rd_state handshake.
module ul_wr_ram_control
  import ul_ram_pkg::*;
#(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned BANK_WORDS = UL_BANK_WORDS,
  parameter int unsigned RAM0_BASE  = UL_RAM0_BASE,
  parameter int unsigned RAM1_BASE  = UL_RAM1_BASE,
  parameter int unsigned CNT_W      = 16
) (
  input logic                clk,
  input logic                nRst,
  ul_wr_ram_control_if.slave bus
);

  localparam logic [UL_OFF_W-1:0] LAST_OFF = UL_OFF_W'(BANK_WORDS - 1);

  ul_wr_state_e      r_state, w_state_d;
  logic              r_bank;
  logic [UL_OFF_W-1:0] r_offset;
  logic [1:0]        r_wr_state;
  logic              r_fill_pend, r_fill_bank;
  logic              r_wr_en, r_frame_err, r_overflow;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_full, w_accept, w_drop, w_frame_err, w_last, w_wr_en;
  logic [UL_OFF_W-1:0] w_wr_off;
  logic [ADDR_W-1:0] w_base, w_addr;
  logic [1:0]        w_fill_mask;

  assign w_full      = (r_wr_state[r_bank] == BANK_FULL);
  // A sync word always lands at offset 0, whether it opens a frame or restarts one.
  assign w_wr_off    = bus.rxFrameSync ? '0 : r_offset;
  assign w_base      = r_bank ? ADDR_W'(RAM1_BASE) : ADDR_W'(RAM0_BASE);
  assign w_addr      = w_base + ADDR_W'(w_wr_off);
  assign w_fill_mask = !r_fill_pend ? 2'b00 : (r_fill_bank ? 2'b10 : 2'b01);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (!bus.UlDataRevEnable) begin
      w_state_d = S_IDLE;
    end else if (bus.rxDataValid) begin
      unique case (r_state)
        S_IDLE:  if (bus.rxFrameSync) w_state_d = w_full ? S_WAIT : S_WR;
        S_WAIT:  if (bus.rxFrameSync && !w_full) w_state_d = S_WR;
        S_WR:    if (!bus.rxFrameSync && (r_offset == LAST_OFF)) w_state_d = S_IDLE;
        default: w_state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_frame_err = 1'b0;
    w_last      = 1'b0;
    w_wr_en     = 1'b0;
    if (bus.UlDataRevEnable && bus.rxDataValid) begin
      unique case (r_state)
        S_IDLE: begin
          w_accept = bus.rxFrameSync && !w_full;
          w_drop   = bus.rxFrameSync && w_full;
        end
        S_WAIT: begin
          w_accept = bus.rxFrameSync && !w_full;
          w_drop   = !w_accept;
        end
        S_WR: begin
          w_wr_en     = 1'b1;
          w_frame_err = bus.rxFrameSync && (r_offset != '0);
          w_last      = !bus.rxFrameSync && (r_offset == LAST_OFF);
        end
        default: ;
      endcase
    end
    w_wr_en = w_wr_en | w_accept;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_bank      <= 1'b0;
      r_offset    <= '0;
      r_wr_state  <= {2{BANK_FREE}};
      r_fill_pend <= 1'b0;
      r_fill_bank <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (!bus.UlDataRevEnable) begin
      r_bank      <= 1'b0;
      r_offset    <= '0;
      r_wr_state  <= {2{BANK_FREE}};
      r_fill_pend <= 1'b0;
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_wr_en     <= w_wr_en;
      r_frame_err <= w_frame_err;
      r_overflow  <= w_drop;
      if (w_wr_en) begin
        r_wr_addr <= w_addr;
        r_wr_data <= bus.rxData;
        r_offset  <= w_last ? '0 : w_wr_off + UL_OFF_W'(1);
      end
      if (w_last) r_bank <= ~r_bank;
      // Full flag trails the last write by one cycle so the reader never sees a half-written bank.
      r_fill_pend <= w_last;
      r_fill_bank <= r_bank;
      r_wr_state  <= (r_wr_state & ~bus.UlRAM_rd_state) | w_fill_mask;
    end
  end

  ul_sat_counter #(
    .CNT_W(CNT_W)
  ) u_drop_cnt (
    .clk    (clk),
    .nRst   (nRst),
    .i_inc  (w_drop),
    .o_count(bus.dropCount)
  );

  assign bus.UlRAM_wr_state = r_wr_state;
  assign bus.wrRAMEn        = r_wr_en;
  assign bus.wrRAMAddr      = r_wr_addr;
  assign bus.wrRAMData      = r_wr_data;
  assign bus.frameErr       = r_frame_err;
  assign bus.overflow       = r_overflow;

endmodule

// File: tb/tb_ul_wr_ram_control.sv
// Directed self-checking bench for the uplink ping-pong RAM write controller.
module tb_ul_wr_ram_control;

  logic clk;
  logic nRst;
  int   n_cmp;
  int   n_err;
  int   ovf_seen;

  ul_wr_ram_control_if #(.DATA_W(10), .ADDR_W(10), .CNT_W(16)) bus ();

  ul_wr_ram_control #(
    .DATA_W    (10),
    .ADDR_W    (10),
    .BANK_WORDS(262),
    .RAM0_BASE (0),
    .RAM1_BASE (512),
    .CNT_W     (16)
  ) dut (
    .clk (clk),
    .nRst(nRst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    bus.rxDataValid     = 1'b0;
    bus.rxFrameSync     = 1'b0;
    bus.UlDataRevEnable = 1'b0;
    tick();
    tick();
    bus.UlDataRevEnable = 1'b1;
  endtask

  // Streams n words of one frame, checking each write (or each drop) the cycle after it.
  task automatic send_frame(input int base, input int n, input bit drop, input int seed);
    logic [9:0] d;
    for (int i = 0; i < n; i++) begin
      d                = 10'((i * 7 + seed) & 10'h3ff);
      bus.rxData       = d;
      bus.rxDataValid  = 1'b1;
      bus.rxFrameSync  = (i == 0);
      tick();
      n_cmp++;
      if (drop) begin
        if (bus.overflow) ovf_seen++;
        if (bus.wrRAMEn !== 1'b0 || bus.overflow !== 1'b1) begin
          n_err++;
          if (n_err < 30) $display("FAIL drop_word[%0d]: en=%b ovf=%b, want en=0 ovf=1",
                                   i, bus.wrRAMEn, bus.overflow);
        end
      end else if (bus.wrRAMEn !== 1'b1 || bus.wrRAMAddr !== 10'(base + i) ||
                   bus.wrRAMData !== d) begin
        n_err++;
        if (n_err < 30) $display("FAIL write_word[%0d]: en=%b addr=%0d data=%h, want 1 %0d %h",
                                 i, bus.wrRAMEn, bus.wrRAMAddr, bus.wrRAMData, 1'b1, base + i, d);
      end
    end
    bus.rxDataValid = 1'b0;
    bus.rxFrameSync = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++;
    if ({bus.wrRAMEn, bus.wrRAMAddr, bus.wrRAMData, bus.UlRAM_wr_state, bus.frameErr,
         bus.overflow, bus.dropCount} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: en=%b addr=%0d wr_state=%b cnt=%0d, want all 0",
               bus.wrRAMEn, bus.wrRAMAddr, bus.UlRAM_wr_state, bus.dropCount);
    end
    nRst = 1'b1;
    tick();
    send_frame(0, 100, 1'b0, 3);
    nRst = 1'b0;
    #1;
    n_cmp++;
    if (bus.wrRAMEn !== 1'b0 || bus.wrRAMAddr !== 10'd0 || bus.UlRAM_wr_state !== 2'b00) begin
      n_err++;
      $display("FAIL reset_midframe: en=%b addr=%0d wr_state=%b, want 0 0 00",
               bus.wrRAMEn, bus.wrRAMAddr, bus.UlRAM_wr_state);
    end
    tick();
    nRst = 1'b1;
    bus.rxData      = 10'h2aa;
    bus.rxDataValid = 1'b1;
    bus.rxFrameSync = 1'b1;
    tick();
    n_cmp++;
    if (bus.wrRAMEn !== 1'b1 || bus.wrRAMAddr !== 10'd0 || bus.wrRAMData !== 10'h2aa) begin
      n_err++;
      $display("FAIL reset_resync: en=%b addr=%0d data=%h, want 1 0 2aa",
               bus.wrRAMEn, bus.wrRAMAddr, bus.wrRAMData);
    end
    flush();
  endtask

  task automatic test_two_frames();
    send_frame(0, 262, 1'b0, 11);
    n_cmp++;
    if (bus.UlRAM_wr_state !== 2'b00) begin
      n_err++;
      $display("FAIL frame0_early_full: wr_state=%b, want 00", bus.UlRAM_wr_state);
    end
    tick();
    n_cmp++;
    if (bus.UlRAM_wr_state !== 2'b01) begin
      n_err++;
      $display("FAIL frame0_full: wr_state=%b, want 01", bus.UlRAM_wr_state);
    end
    bus.UlRAM_rd_state = 2'b01;
    for (int c = 0; c < 6; c++) tick();
    bus.UlRAM_rd_state = 2'b00;
    send_frame(512, 262, 1'b0, 29);
    tick();
    n_cmp++;
    if (bus.UlRAM_wr_state !== 2'b10) begin
      n_err++;
      $display("FAIL frame1_full: wr_state=%b, want 10", bus.UlRAM_wr_state);
    end
    bus.UlRAM_rd_state = 2'b10;
    for (int c = 0; c < 6; c++) tick();
    bus.UlRAM_rd_state = 2'b00;
    n_cmp++;
    if (bus.UlRAM_wr_state !== 2'b00) begin
      n_err++;
      $display("FAIL frame1_release: wr_state=%b, want 00", bus.UlRAM_wr_state);
    end
  endtask

  task automatic test_release();
    flush();
    send_frame(0, 262, 1'b0, 5);
    tick();
    bus.UlRAM_rd_state = 2'b10;
    for (int c = 0; c < 6; c++) tick();
    n_cmp++;
    if (bus.UlRAM_wr_state !== 2'b01) begin
      n_err++;
      $display("FAIL release_ignored: wr_state=%b, want 01", bus.UlRAM_wr_state);
    end
    bus.UlRAM_rd_state = 2'b01;
    tick();
    n_cmp++;
    if (bus.UlRAM_wr_state !== 2'b00) begin
      n_err++;
      $display("FAIL release_cycle1: wr_state=%b, want 00", bus.UlRAM_wr_state);
    end
    for (int c = 0; c < 5; c++) tick();
    bus.UlRAM_rd_state = 2'b00;
    tick();
    n_cmp++;
    if (bus.UlRAM_wr_state !== 2'b00) begin
      n_err++;
      $display("FAIL release_hold: wr_state=%b, want 00", bus.UlRAM_wr_state);
    end
  endtask

  task automatic test_frame_err();
    flush();
    send_frame(0, 50, 1'b0, 17);
    bus.rxData      = 10'h155;
    bus.rxDataValid = 1'b1;
    bus.rxFrameSync = 1'b1;
    tick();
    n_cmp++;
    if (bus.frameErr !== 1'b1 || bus.wrRAMAddr !== 10'd0 || bus.wrRAMData !== 10'h155) begin
      n_err++;
      $display("FAIL frame_err_restart: err=%b addr=%0d data=%h, want 1 0 155",
               bus.frameErr, bus.wrRAMAddr, bus.wrRAMData);
    end
    bus.rxData      = 10'h0aa;
    bus.rxFrameSync = 1'b0;
    tick();
    n_cmp++;
    if (bus.frameErr !== 1'b0 || bus.wrRAMAddr !== 10'd1 || bus.wrRAMEn !== 1'b1) begin
      n_err++;
      $display("FAIL frame_err_next: err=%b addr=%0d en=%b, want 0 1 1",
               bus.frameErr, bus.wrRAMAddr, bus.wrRAMEn);
    end
    bus.rxDataValid = 1'b0;
    flush();
  endtask

  task automatic test_overflow();
    send_frame(0, 262, 1'b0, 41);
    send_frame(512, 262, 1'b0, 43);
    tick();
    n_cmp++;
    if (bus.UlRAM_wr_state !== 2'b11) begin
      n_err++;
      $display("FAIL both_full: wr_state=%b, want 11", bus.UlRAM_wr_state);
    end
    ovf_seen = 0;
    send_frame(0, 262, 1'b1, 47);
    n_cmp++;
    if (ovf_seen != 262 || bus.dropCount !== 16'd262) begin
      n_err++;
      $display("FAIL drop_count: pulses=%0d cnt=%0d, want 262 262", ovf_seen, bus.dropCount);
    end
    tick();
    n_cmp++;
    if (bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_idle: ovf=%b, want 0", bus.overflow);
    end
  endtask

  task automatic test_enable_drop();
    bus.UlRAM_rd_state = 2'b11;
    tick();
    bus.UlRAM_rd_state = 2'b00;
    send_frame(0, 262, 1'b0, 53);
    tick();
    send_frame(512, 200, 1'b0, 59);
    bus.UlDataRevEnable = 1'b0;
    tick();
    n_cmp++;
    if (bus.UlRAM_wr_state !== 2'b00 || bus.wrRAMEn !== 1'b0) begin
      n_err++;
      $display("FAIL disable_flush: wr_state=%b en=%b, want 00 0", bus.UlRAM_wr_state,
               bus.wrRAMEn);
    end
    bus.UlDataRevEnable = 1'b1;
    tick();
    n_cmp++;
    if (bus.dropCount !== 16'd262) begin
      n_err++;
      $display("FAIL disable_keeps_count: cnt=%0d, want 262", bus.dropCount);
    end
    bus.rxData      = 10'h3c3;
    bus.rxDataValid = 1'b1;
    bus.rxFrameSync = 1'b1;
    tick();
    bus.rxDataValid = 1'b0;
    bus.rxFrameSync = 1'b0;
    n_cmp++;
    if (bus.wrRAMEn !== 1'b1 || bus.wrRAMAddr !== 10'd0 || bus.wrRAMData !== 10'h3c3) begin
      n_err++;
      $display("FAIL disable_next_bank0: en=%b addr=%0d data=%h, want 1 0 3c3",
               bus.wrRAMEn, bus.wrRAMAddr, bus.wrRAMData);
    end
  endtask

  initial begin
    n_cmp               = 0;
    n_err               = 0;
    ovf_seen            = 0;
    nRst                = 1'b0;
    bus.UlDataRevEnable = 1'b1;
    bus.rxData          = '0;
    bus.rxDataValid     = 1'b0;
    bus.rxFrameSync     = 1'b0;
    bus.UlRAM_rd_state  = 2'b00;
    test_reset();
    test_two_frames();
    test_release();
    test_frame_err();
    test_overflow();
    test_enable_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
